// File: rtl/io_register_bank.sv
// io_register_bank
//   Memory-mapped I/O block with three decoded regions selected by
//   address[13:12]:
//     2'b01  input channels, read-only, each pin passed through a
//            2-flop synchroniser
//     2'b10  N_OUT 32-bit output registers with byte/half/word writes,
//            mirrored on io_output_bus
//     2'b11  edge-capture registers (only with IO_EDGE_CAPTURE_EN defined;
//            otherwise reads 0, writes ignored, irq tied low)
//   Reads have one cycle of latency with registered q/q_valid. Accesses
//   whose offset does not match the access size are rejected and flagged
//   on misaligned one cycle later.
//
//   Optional feature macro: IO_EDGE_CAPTURE_EN
//
// Ports
//   clock, reset      rising-edge clock, synchronous active-high reset
//   address           byte address: [13:12] region, [5:2] word index,
//                     [1:0] byte offset
//   mem_mode          2'b00 byte, 2'b01 half, 2'b10 word
//   mem_unsigned      zero-extend loads when high
//   wren, rden        write / read request (wren wins)
//   data              right-aligned store data
//   q, q_valid        load data and its one-cycle valid strobe
//   misaligned        one-cycle pulse for a rejected access
//   io_input_bus      channel c at [c*IN_WIDTH +: IN_WIDTH]
//   io_output_bus     register k at [k*32 +: 32]
//   irq               registered OR of all capture bits
module io_register_bank #(
    parameter int unsigned N_OUT    = 2,
    parameter int unsigned N_IN     = 5,
    parameter int unsigned IN_WIDTH = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [31:0]                address,
    input  logic [1:0]                 mem_mode,
    input  logic                       mem_unsigned,
    input  logic                       wren,
    input  logic                       rden,
    input  logic [31:0]                data,
    output logic [31:0]                q,
    output logic                       q_valid,
    output logic                       misaligned,
    input  logic [N_IN*IN_WIDTH-1:0]   io_input_bus,
    output logic [N_OUT*32-1:0]        io_output_bus,
    output logic                       irq
);

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_mode_t;

    typedef enum logic [1:0] {
        REGION_NONE    = 2'b00,
        REGION_INPUT   = 2'b01,
        REGION_OUTPUT  = 2'b10,
        REGION_CAPTURE = 2'b11
    } region_t;

    mem_mode_t                  mode;
    region_t                    region;
    logic [1:0]                 offset;
    logic [9:0]                 index;
    logic                       bad_align;
    logic                       do_write;
    logic                       do_read;
    logic [3:0]                 lane_mask;
    logic [31:0]                byte_mask;
    logic [31:0]                write_word;
    logic [31:0]                sel_word;
    logic [31:0]                shifted;
    logic [31:0]                read_data;
    logic [N_OUT*32-1:0]        out_regs;
    logic [N_IN*IN_WIDTH-1:0]   sync1;
    logic [N_IN*IN_WIDTH-1:0]   sync2;
    logic                       unused_addr_bits;

    assign mode   = mem_mode_t'(mem_mode);
    assign region = region_t'(address[13:12]);
    assign offset = address[1:0];
    // Word index is decoded from [11:2]: any set bit above [5:2] means an
    // index of 16 or more, which never matches a channel or register.
    assign index  = address[11:2];

    assign unused_addr_bits = ^address[31:14];

    // Access decode, byte-lane selection and store-data replication
    always_comb begin
        bad_align  = 1'b0;
        lane_mask  = 4'b1111;
        write_word = data;
        case (mode)
            MEM_BYTE: begin
                lane_mask  = 4'b0001 << offset;
                write_word = {4{data[7:0]}};
            end
            MEM_HALF: begin
                bad_align  = offset[0];
                lane_mask  = 4'b0011 << offset;
                write_word = {2{data[15:0]}};
            end
            default: begin
                bad_align  = (offset != 2'b00);
            end
        endcase
        byte_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}},
                     {8{lane_mask[1]}}, {8{lane_mask[0]}}};
        do_write  = wren & ~bad_align;
        do_read   = rden & ~wren & ~bad_align;
    end

`ifdef IO_EDGE_CAPTURE_EN
    logic [N_IN*IN_WIDTH-1:0]   sync_prev;
    logic [N_IN*IN_WIDTH-1:0]   capture;
    logic [N_IN*IN_WIDTH-1:0]   capture_clear;
    logic [31:0]                clear_word;

    // Write-1-to-clear bits for the addressed channel, same lane rules
    always_comb begin
        capture_clear = '0;
        clear_word    = write_word & byte_mask;
        if (do_write && region == REGION_CAPTURE) begin
            for (int unsigned c = 0; c < N_IN; c++) begin
                if (index == c[9:0]) begin
                    capture_clear[c*IN_WIDTH +: IN_WIDTH] = clear_word[IN_WIDTH-1:0];
                end
            end
        end
    end

    // Set wins over clear: the rising-edge term is OR-ed in after clearing
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_prev <= '0;
            capture   <= '0;
            irq       <= 1'b0;
        end else begin
            sync_prev <= sync2;
            capture   <= (capture & ~capture_clear) | (sync2 & ~sync_prev);
            irq       <= |capture;
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Read word selection
    always_comb begin
        sel_word = '0;
        case (region)
            REGION_INPUT: begin
                for (int unsigned c = 0; c < N_IN; c++) begin
                    if (index == c[9:0]) begin
                        sel_word[IN_WIDTH-1:0] = sync2[c*IN_WIDTH +: IN_WIDTH];
                    end
                end
            end
            REGION_OUTPUT: begin
                for (int unsigned k = 0; k < N_OUT; k++) begin
                    if (index == k[9:0]) begin
                        sel_word = out_regs[k*32 +: 32];
                    end
                end
            end
            REGION_CAPTURE: begin
`ifdef IO_EDGE_CAPTURE_EN
                for (int unsigned c = 0; c < N_IN; c++) begin
                    if (index == c[9:0]) begin
                        sel_word[IN_WIDTH-1:0] = capture[c*IN_WIDTH +: IN_WIDTH];
                    end
                end
`endif
            end
            default: sel_word = '0;
        endcase
    end

    // Align to the byte offset, then mask and extend
    always_comb begin
        shifted   = sel_word >> {offset, 3'b000};
        read_data = shifted;
        case (mode)
            MEM_BYTE: read_data = mem_unsigned ? {24'h0, shifted[7:0]}
                                               : {{24{shifted[7]}}, shifted[7:0]};
            MEM_HALF: read_data = mem_unsigned ? {16'h0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
            default:  read_data = shifted;
        endcase
    end

    // Output registers, synchronisers and registered read response
    always_ff @(posedge clock) begin
        if (reset) begin
            out_regs   <= '0;
            sync1      <= '0;
            sync2      <= '0;
            q          <= '0;
            q_valid    <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            sync1      <= io_input_bus;
            sync2      <= sync1;
            q_valid    <= do_read;
            misaligned <= (wren | rden) & bad_align;
            if (do_read) begin
                q <= read_data;
            end
            if (do_write && region == REGION_OUTPUT) begin
                for (int unsigned k = 0; k < N_OUT; k++) begin
                    if (index == k[9:0]) begin
                        out_regs[k*32 +: 32] <= (out_regs[k*32 +: 32] & ~byte_mask)
                                              | (write_word & byte_mask);
                    end
                end
            end
        end
    end

    assign io_output_bus = out_regs;

endmodule
